// File: rtl/deco_8_lineas_sec_if.sv
// Eight-line decoder bus: valid/ready code input plus the registered one-hot line outputs.
// The decoder sits on the slave side. The producer of line numbers is the master.
interface deco_8_lineas_sec_if #(
  parameter int N_OUT = 8,
  parameter int W_IN  = 3
);
  logic             in_valid;
  logic [W_IN-1:0]  in_code;
  logic             in_ready;
  logic [N_OUT-1:0] ocho_lineas;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output in_valid,
    output in_code,
    input  in_ready,
    input  ocho_lineas,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_code,
    output in_ready,
    output ocho_lineas,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/deco_8_lineas_sec.sv
// Sequential 3-to-8 line decoder: accepts a binary code over valid/ready, drives one line high
// for HOLD cycles, then keeps every line low for GAP cycles before it accepts the next code.
module deco_8_lineas_sec #(
  parameter int N_OUT = 8,
  parameter int W_IN  = 3,
  parameter int HOLD  = 4,
  parameter int GAP   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  deco_8_lineas_sec_if.slave bus
);

  localparam int               MAX_CNT   = (HOLD > GAP) ? HOLD : GAP;
  localparam int               CNT_W     = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [W_IN:0]    N_OUT_W   = (W_IN + 1)'(N_OUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP
  } state_t;

  state_t           state_q;
  state_t           state_n;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;
  logic [N_OUT-1:0] lines_q;
  logic [N_OUT-1:0] lines_n;
  logic             done_q;
  logic             done_n;
  logic             err_q;
  logic             err_n;
  logic [N_OUT-1:0] line_dec;
  logic             ready;
  logic             xfer;
  logic             code_ok;

  // Ready drops with reset itself, so nothing can be accepted while rst_n is low.
  assign ready   = rst_n & (state_q == S_IDLE);
  assign xfer    = bus.in_valid & ready;
  assign code_ok = ({1'b0, bus.in_code} < N_OUT_W);

  always_comb begin
    line_dec = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (bus.in_code == W_IN'(i)) begin
        line_dec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    lines_n = lines_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (code_ok) begin
            lines_n = line_dec;
            cnt_n   = HOLD_LOAD;
            state_n = S_DRIVE;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          lines_n = '0;
          done_n  = 1'b1;
          if (GAP > 0) begin
            cnt_n   = GAP_LOAD;
            state_n = S_GAP;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_GAP: begin
        lines_n = '0;
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          state_n = S_IDLE;
        end
      end
      default: begin
        lines_n = '0;
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // An in-flight code is simply dropped on reset: lines clear at once and no done is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lines_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      lines_q <= lines_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.ocho_lineas = lines_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_deco_8_lineas_sec.sv
// Scoreboard bench for deco_8_lineas_sec: two instances (8 lines HOLD=4 GAP=1, 6 lines HOLD=1 GAP=0)
// driven by sweep, held-valid, reset and random phases, checked against a cycle-budget model.
module tb_deco_8_lineas_sec;

  typedef struct {
    bit is_err;
    int code;
    int cyc;
  } sb_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  int         cyc   = 0;
  int         phase = 0;
  int         vectors     = 0;
  int         miscompares = 0;

  logic       stim_valid [2];
  logic [2:0] stim_code  [2];
  int         busy_left  [2];
  int         nout       [2];
  int         hold       [2];
  int         gap        [2];
  int         sweep      [2];
  int         last_phase [2];
  bit         sent       [2];
  bit         accepted   [2];
  bit         in_run     [2];
  int         run_len    [2];
  int         run_start  [2];
  logic [7:0] run_val    [2];
  sb_t        sb_q0 [$];
  sb_t        sb_q1 [$];

  deco_8_lineas_sec_if #(.N_OUT(8), .W_IN(3)) bus0 ();
  deco_8_lineas_sec_if #(.N_OUT(6), .W_IN(3)) bus1 ();

  assign bus0.in_valid = stim_valid[0];
  assign bus0.in_code  = stim_code[0];
  assign bus1.in_valid = stim_valid[1];
  assign bus1.in_code  = stim_code[1];

  deco_8_lineas_sec #(.N_OUT(8), .W_IN(3), .HOLD(4), .GAP(1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  deco_8_lineas_sec #(.N_OUT(6), .W_IN(3), .HOLD(1), .GAP(0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compareVal(int k, string name, int actual, int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL dut%0d %s @cycle %0d: got 0x%0h, expected 0x%0h", k, name, cyc, actual, expected);
    end
  endtask

  function automatic int sbSize(int k);
    return (k == 0) ? sb_q0.size() : sb_q1.size();
  endfunction

  task automatic sbPush(int k, sb_t e);
    if (k == 0) sb_q0.push_back(e);
    else        sb_q1.push_back(e);
  endtask

  task automatic sbPop(int k, output sb_t e);
    if (k == 0) e = sb_q0.pop_front();
    else        e = sb_q1.pop_front();
  endtask

  task automatic sbFlush(int k);
    if (k == 0) sb_q0.delete();
    else        sb_q1.delete();
  endtask

  // Reference: a code is taken whenever valid is high and the previous line plus gap have elapsed.
  task automatic modelEdge(int k);
    sb_t e;
    if (!rst_n) begin
      busy_left[k] = 0;
      return;
    end
    if (stim_valid[k] && busy_left[k] == 0) begin
      accepted[k] = 1'b1;
      e.code = int'(stim_code[k]);
      e.cyc  = cyc;
      e.is_err = (e.code >= nout[k]);
      if (!e.is_err) busy_left[k] = hold[k] + gap[k];
      sbPush(k, e);
    end else if (busy_left[k] > 0) begin
      busy_left[k]--;
    end
  endtask

  task automatic applyStimulus(int k);
    if (accepted[k]) begin
      sent[k]     = 1'b1;
      sweep[k]    = (sweep[k] + 1) % 8;
      accepted[k] = 1'b0;
    end
    if (phase != last_phase[k]) begin
      sent[k]       = 1'b0;
      last_phase[k] = phase;
    end
    case (phase)
      1: begin stim_valid[k] = 1'b1;     stim_code[k] = 3'(sweep[k]); end
      2: begin stim_valid[k] = 1'b1;     stim_code[k] = 3'd3; end
      3: begin stim_valid[k] = ($urandom_range(0, 99) < 60); stim_code[k] = 3'($urandom_range(0, 7)); end
      4: begin stim_valid[k] = !sent[k]; stim_code[k] = 3'd5; end
      5: begin stim_valid[k] = !sent[k]; stim_code[k] = 3'd2; end
      default: begin stim_valid[k] = 1'b0; stim_code[k] = 3'($urandom_range(0, 7)); end
    endcase
  endtask

  task automatic checkOutput(int k);
    logic [7:0] l;
    logic       rdy, bsy, dn, er;
    sb_t        e;
    if (k == 0) begin
      l = bus0.ocho_lineas; rdy = bus0.in_ready; bsy = bus0.busy; dn = bus0.done; er = bus0.err;
    end else begin
      l = 8'(bus1.ocho_lineas); rdy = bus1.in_ready; bsy = bus1.busy; dn = bus1.done; er = bus1.err;
    end
    if (!rst_n) begin
      sbFlush(k);
      in_run[k] = 1'b0;
      compareVal(k, "reset_lines", int'(l), 0);
      compareVal(k, "reset_ready", int'(rdy), 0);
      compareVal(k, "reset_busy", int'(bsy), 0);
      compareVal(k, "reset_done", int'(dn), 0);
      compareVal(k, "reset_err", int'(er), 0);
      return;
    end
    compareVal(k, "in_ready", int'(rdy), int'(busy_left[k] == 0));
    compareVal(k, "busy", int'(bsy), int'(busy_left[k] != 0));
    compareVal(k, "onehot", int'($countones(l) <= 1), 1);
    if (er) begin
      compareVal(k, "err_pending", int'(sbSize(k) != 0), 1);
      if (sbSize(k) != 0) begin
        sbPop(k, e);
        compareVal(k, "err_kind", int'(e.is_err), 1);
        compareVal(k, "err_cycle", cyc, e.cyc);
      end
    end
    if (l != 8'h00) begin
      if (!in_run[k]) begin
        in_run[k]    = 1'b1;
        run_val[k]   = l;
        run_len[k]   = 1;
        run_start[k] = cyc;
      end else begin
        compareVal(k, "line_stable", int'(l), int'(run_val[k]));
        run_len[k]++;
      end
      compareVal(k, "done_while_high", int'(dn), 0);
    end else if (in_run[k]) begin
      in_run[k] = 1'b0;
      compareVal(k, "done_pulse", int'(dn), 1);
      compareVal(k, "line_pending", int'(sbSize(k) != 0), 1);
      if (sbSize(k) != 0) begin
        sbPop(k, e);
        compareVal(k, "line_kind", int'(e.is_err), 0);
        compareVal(k, "line_value", int'(run_val[k]), 1 << e.code);
        compareVal(k, "hold_len", run_len[k], hold[k]);
        compareVal(k, "latency", run_start[k], e.cyc);
      end
    end else begin
      compareVal(k, "spurious_done", int'(dn), 0);
    end
  endtask

  initial begin
    nout[0] = 8; hold[0] = 4; gap[0] = 1;
    nout[1] = 6; hold[1] = 1; gap[1] = 0;
    for (int k = 0; k < 2; k++) begin
      stim_valid[k] = 1'b0; stim_code[k] = 3'd0; busy_left[k] = 0; sweep[k] = 0;
      last_phase[k] = 0; sent[k] = 1'b0; accepted[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        modelEdge(k);
        applyStimulus(k);
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      in_run[k] = 1'b0; run_len[k] = 0; run_start[k] = 0; run_val[k] = 8'h00;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) checkOutput(k);
  end

  initial begin
    $display("[TB] start");
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk) phase = 1;
    repeat (70) @(negedge clk);
    phase = 2;
    repeat (40) @(negedge clk);
    phase = 0;
    repeat (10) @(negedge clk);

    // Code 5 is taken on the second edge; the third negedge falls in its second hold cycle.
    phase = 4;
    repeat (3) @(negedge clk);
    compareVal(0, "line_before_reset", int'(bus0.ocho_lineas), 'h20);
    #1 rst_n = 1'b0;
    #1;
    compareVal(0, "async_clear", int'(bus0.ocho_lineas), 0);
    compareVal(1, "async_clear", int'(bus1.ocho_lineas), 0);
    compareVal(0, "async_busy", int'(bus0.busy), 0);
    compareVal(0, "async_done", int'(bus0.done), 0);
    phase = 5;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    compareVal(0, "first_after_reset", int'(bus0.ocho_lineas), 'h04);
    compareVal(1, "first_after_reset", int'(bus1.ocho_lineas), 'h04);

    phase = 3;
    repeat (2000) @(negedge clk);
    phase = 0;
    repeat (20) @(negedge clk);
    compareVal(0, "scoreboard_drained", sbSize(0), 0);
    compareVal(1, "scoreboard_drained", sbSize(1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
